// File: rtl/fpu_compute_pipe_if.sv
// ============================================================================
//  Module   : fpu_compute_pipe_if
//  Brief    : Handshake and data bundle between align, compute and normalise.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fpu_compute_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24,
    parameter int TAG_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_sign_1;
    logic                 in_sign_2;
    logic [EXP_W-1:0]     in_exponent;
    logic [MAN_W-1:0]     in_mantissa_1;
    logic [MAN_W-1:0]     in_mantissa_2;
    logic [1:0]           in_operator;
    logic [TAG_W-1:0]     in_tag;

    logic                 out_valid;
    logic                 out_ready;
    logic                 sign;
    logic [EXP_W-1:0]     exponent;
    logic [2*MAN_W-1:0]   mantissa;
    logic [1:0]           operator;
    logic [TAG_W-1:0]     tag;
    logic                 zero;

    // master: the side that feeds operands and consumes results
    modport master (
        output in_valid, in_sign_1, in_sign_2, in_exponent,
               in_mantissa_1, in_mantissa_2, in_operator, in_tag, out_ready,
        input  in_ready, out_valid, sign, exponent, mantissa, operator, tag, zero
    );

    modport slave (
        input  in_valid, in_sign_1, in_sign_2, in_exponent,
               in_mantissa_1, in_mantissa_2, in_operator, in_tag, out_ready,
        output in_ready, out_valid, sign, exponent, mantissa, operator, tag, zero
    );
endinterface

`default_nettype wire

// File: rtl/fpu_compute_pipe.sv
// ============================================================================
//  Module   : fpu_compute_pipe
//  Brief    : Add/sub/multiply on pre-aligned mantissas, LAT-deep stall pipe.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_compute_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24,
    parameter int TAG_W = 4,
    parameter int LAT   = 2
) (
    input  wire logic           clk,
    input  wire logic           rst,
    fpu_compute_pipe_if.slave   bus_io
);

    localparam int         c_RES_W  = 2 * MAN_W;
    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_MUL = 2'b10;

    logic                 w_adv;
    logic                 w_s2e;
    logic [c_RES_W-1:0]   w_m1;
    logic [c_RES_W-1:0]   w_m2;

    logic                 sign_d;
    logic [c_RES_W-1:0]   man_d;
    logic                 zero_d;

    logic                 valid_q [LAT];
    logic                 sign_q  [LAT];
    logic [EXP_W-1:0]     exp_q   [LAT];
    logic [c_RES_W-1:0]   man_q   [LAT];
    logic [1:0]           op_q    [LAT];
    logic [TAG_W-1:0]     tag_q   [LAT];
    logic                 zero_q  [LAT];

    // The whole pipe moves in lockstep; a held output freezes every stage.
    assign w_adv           = !valid_q[LAT-1] || bus_io.out_ready;
    assign bus_io.in_ready = w_adv;

    assign w_m1  = {{MAN_W{1'b0}}, bus_io.in_mantissa_1};
    assign w_m2  = {{MAN_W{1'b0}}, bus_io.in_mantissa_2};
    assign w_s2e = bus_io.in_sign_2 ^ (bus_io.in_operator == c_OP_SUB);

    always_comb begin
        sign_d = 1'b0;
        man_d  = '0;
        case (bus_io.in_operator)
            c_OP_ADD, c_OP_SUB: begin
                if (bus_io.in_sign_1 == w_s2e) begin
                    man_d  = w_m1 + w_m2;
                    sign_d = bus_io.in_sign_1;
                end else if (bus_io.in_mantissa_1 >= bus_io.in_mantissa_2) begin
                    man_d  = w_m1 - w_m2;
                    // exact cancellation always yields +0
                    sign_d = (bus_io.in_mantissa_1 == bus_io.in_mantissa_2) ? 1'b0
                                                                            : bus_io.in_sign_1;
                end else begin
                    man_d  = w_m2 - w_m1;
                    sign_d = w_s2e;
                end
            end
            c_OP_MUL: begin
                man_d  = w_m1 * w_m2;
                sign_d = bus_io.in_sign_1 ^ bus_io.in_sign_2;
            end
            default: begin
                man_d  = '0;
                sign_d = 1'b0;
            end
        endcase
        zero_d = (man_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) begin
                valid_q[k] <= 1'b0;
                sign_q[k]  <= 1'b0;
                exp_q[k]   <= '0;
                man_q[k]   <= '0;
                op_q[k]    <= '0;
                tag_q[k]   <= '0;
                zero_q[k]  <= 1'b0;
            end
        end else if (w_adv) begin
            valid_q[0] <= bus_io.in_valid;
            sign_q[0]  <= sign_d;
            exp_q[0]   <= bus_io.in_exponent;
            man_q[0]   <= man_d;
            op_q[0]    <= bus_io.in_operator;
            tag_q[0]   <= bus_io.in_tag;
            zero_q[0]  <= zero_d;
            for (int k = 1; k < LAT; k++) begin
                valid_q[k] <= valid_q[k-1];
                sign_q[k]  <= sign_q[k-1];
                exp_q[k]   <= exp_q[k-1];
                man_q[k]   <= man_q[k-1];
                op_q[k]    <= op_q[k-1];
                tag_q[k]   <= tag_q[k-1];
                zero_q[k]  <= zero_q[k-1];
            end
        end
    end

    assign bus_io.out_valid = valid_q[LAT-1];
    assign bus_io.sign      = sign_q[LAT-1];
    assign bus_io.exponent  = exp_q[LAT-1];
    assign bus_io.mantissa  = man_q[LAT-1];
    assign bus_io.operator  = op_q[LAT-1];
    assign bus_io.tag       = tag_q[LAT-1];
    assign bus_io.zero      = zero_q[LAT-1];

endmodule

`default_nettype wire

// File: tb/tb_fpu_compute_pipe.sv
// ============================================================================
//  Module   : tb_fpu_compute_pipe
//  Brief    : Directed and randomized checks of fpu_compute_pipe vs. a model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_compute_pipe;

    localparam int EXP_W = 8;
    localparam int MAN_W = 24;
    localparam int TAG_W = 4;
    localparam int LAT   = 2;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [47:0] man;
        logic [1:0]  op;
        logic [3:0]  tag;
        logic        zero;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fpu_compute_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) bus ();

    fpu_compute_pipe #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W),
        .TAG_W (TAG_W),
        .LAT   (LAT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    int   n_checks  = 0;
    int   n_pass    = 0;
    int   cyc       = 0;
    int   deliv     = 0;
    int   first_del = -1;
    int   last_del  = 0;
    int   last_acc  = 0;
    int   stall_lo  = -1;
    int   stall_hi  = -1;
    bit   rand_ready = 1'b0;
    bit   ovr_valid  = 1'b0;
    bit   stall_prev = 1'b0;
    res_t ovr;
    res_t snap;
    res_t q[$];

    // Signed-integer view of the operands: the result is simply |v1 + v2|.
    function automatic res_t model(input logic s1, input logic s2, input logic [7:0] e,
                                   input logic [23:0] m1, input logic [23:0] m2,
                                   input logic [1:0] op, input logic [3:0] tg);
        res_t   r;
        longint a, b, sum;
        logic   s2e;
        r     = '0;
        r.exp = e;
        r.op  = op;
        r.tag = tg;
        a     = longint'(m1);
        b     = longint'(m2);
        case (op)
            2'b00, 2'b01: begin
                s2e    = s2 ^ (op == 2'b01);
                sum    = (s1 ? -a : a) + (s2e ? -b : b);
                r.sign = (sum < 0) || (sum == 0 && s1 && s2e);
                r.man  = 48'((sum < 0) ? -sum : sum);
            end
            2'b10: begin
                r.man  = 48'(a * b);
                r.sign = s1 ^ s2;
            end
            default: ;
        endcase
        r.zero = (r.man == 48'd0);
        return r;
    endfunction

    function automatic res_t observed();
        return {bus.sign, bus.exponent, bus.mantissa, bus.operator, bus.tag, bus.zero};
    endfunction

    function automatic logic [23:0] rand_man();
        case ($urandom_range(0, 7))
            0:       return 24'd0;
            1:       return 24'hFFFFFF;
            default: return 24'($urandom_range(0, 32'h00FF_FFFF));
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    // One clock: inputs are set by the caller just after a falling edge.
    task automatic step(output bit acc);
        res_t obs, e;
        acc = 1'b0;
        bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (cyc >= stall_lo && cyc < stall_hi) bus.out_ready = 1'b0;
        #1;
        obs = observed();
        if (stall_prev) begin
            check("stall_hold_valid", 64'(bus.out_valid), 64'd1);
            check("stall_hold_data", obs, snap);
        end
        if (bus.out_valid && !bus.out_ready) check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        if (bus.out_valid && bus.out_ready) begin
            check("expected_pending", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("sign",     64'(obs.sign), 64'(e.sign));
                check("exponent", 64'(obs.exp),  64'(e.exp));
                check("mantissa", 64'(obs.man),  64'(e.man));
                check("operator", 64'(obs.op),   64'(e.op));
                check("tag",      64'(obs.tag),  64'(e.tag));
                check("zero",     64'(obs.zero), 64'(e.zero));
            end
            deliv++;
            last_del = cyc;
            if (first_del < 0) first_del = cyc;
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        snap       = obs;
        if (bus.in_valid && bus.in_ready) begin
            acc      = 1'b1;
            last_acc = cyc;
            q.push_back(ovr_valid ? ovr
                                  : model(bus.in_sign_1, bus.in_sign_2, bus.in_exponent,
                                          bus.in_mantissa_1, bus.in_mantissa_2,
                                          bus.in_operator, bus.in_tag));
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic s1, input logic s2, input logic [7:0] e,
                        input logic [23:0] m1, input logic [23:0] m2,
                        input logic [1:0] op, input logic [3:0] tg,
                        input bit use_ovr, input logic es, input logic [47:0] em);
        bit acc;
        int n;
        bus.in_valid      = 1'b1;
        bus.in_sign_1     = s1;
        bus.in_sign_2     = s2;
        bus.in_exponent   = e;
        bus.in_mantissa_1 = m1;
        bus.in_mantissa_2 = m2;
        bus.in_operator   = op;
        bus.in_tag        = tg;
        ovr_valid         = use_ovr;
        ovr               = {es, e, em, op, tg, (em == 48'd0)};
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            step(acc);
            n++;
        end
        if (!acc) check("accept_timeout", 64'(acc), 64'd1);
        bus.in_valid = 1'b0;
        ovr_valid    = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 200 && q.size() != 0; i++) step(acc);
        check("drain_pending", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int c0;
        bus.in_valid      = 1'b0;
        bus.in_sign_1     = 1'b0;
        bus.in_sign_2     = 1'b0;
        bus.in_exponent   = '0;
        bus.in_mantissa_1 = '0;
        bus.in_mantissa_2 = '0;
        bus.in_operator   = '0;
        bus.in_tag        = '0;
        bus.out_ready     = 1'b1;

        #1 rst = 1'b1;
        #1;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_outputs",   observed(),         64'd0);
        check("reset_in_ready",  64'(bus.in_ready),  64'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors with literal expected results.
        send(0, 0, 8'h7F, 24'h800000, 24'h800000, 2'b00, 4'd3, 1, 1'b0, 48'h000001000000);
        drain();
        check("latency", 64'(last_del - last_acc), 64'(LAT));
        send(0, 0, 8'h10, 24'h400000, 24'h800000, 2'b01, 4'd4, 1, 1'b1, 48'h000000400000);
        send(1, 0, 8'h11, 24'h400000, 24'h800000, 2'b00, 4'd5, 1, 1'b0, 48'h000000400000);
        send(1, 0, 8'h12, 24'h800000, 24'h800000, 2'b10, 4'd6, 1, 1'b1, 48'h400000000000);
        send(0, 0, 8'h13, 24'hFFFFFF, 24'hFFFFFF, 2'b10, 4'd7, 1, 1'b0, 48'hFFFFFE000001);
        send(0, 0, 8'h14, 24'hFFFFFF, 24'hFFFFFF, 2'b00, 4'd8, 1, 1'b0, 48'h000001FFFFFE);
        send(1, 1, 8'h15, 24'h123456, 24'h123456, 2'b01, 4'd9, 1, 1'b0, 48'h0);
        send(1, 0, 8'h16, 24'hABCDEF, 24'h000777, 2'b11, 4'd10, 1, 1'b0, 48'h0);
        send(0, 0, 8'h17, 24'h000000, 24'h000000, 2'b00, 4'd11, 1, 1'b0, 48'h0);
        send(1, 0, 8'h18, 24'h000000, 24'h00F00D, 2'b10, 4'd12, 1, 1'b1, 48'h0);
        drain();

        // Back-pressure: five tagged adds, out_ready low for 3 cycles mid-stream.
        deliv     = 0;
        first_del = -1;
        c0        = cyc;
        stall_lo  = c0 + LAT + 1;
        stall_hi  = stall_lo + 3;
        for (int i = 0; i < 5; i++)
            send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 rand_man(), rand_man(), 2'b00, 4'(i), 0, 1'b0, 48'h0);
        drain();
        stall_lo = -1;
        stall_hi = -1;
        check("bp_delivered", 64'(deliv), 64'd5);
        check("bp_span",      64'(last_del - first_del), 64'd7);

        // Reset with two transactions in flight.
        send(0, 0, 8'h21, 24'h000100, 24'h000200, 2'b00, 4'd1, 0, 1'b0, 48'h0);
        send(0, 1, 8'h22, 24'h000300, 24'h000200, 2'b10, 4'd2, 0, 1'b0, 48'h0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("async_rst_outputs",   observed(),         64'd0);
        check("async_rst_in_ready",  64'(bus.in_ready),  64'd1);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        stall_prev = 1'b0;
        deliv      = 0;
        idle(6);
        check("post_reset_outputs", 64'(deliv), 64'd0);

        // Randomized traffic with random back-pressure against the model.
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            logic [23:0] m1, m2;
            m1 = rand_man();
            m2 = ($urandom_range(0, 7) == 0) ? m1 : rand_man();
            send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 m1, m2, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 0, 1'b0, 48'h0);
            idle($urandom_range(0, 2));
        end
        drain();
        rand_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fpu_compute_pipe.md
Name: fpu_compute_pipe

Overview:
- Parametrised, handshaked successor to the FPU compute stage.
- Takes pre-aligned operands from the align stage: shared exponent plus two unsigned mantissas with separate signs.
- Performs add, subtract or multiply, with a correct result sign for effective subtraction.
- Carries the result through a configurable-depth register pipeline to the normalise stage, with valid/ready flow control and a transaction tag.

Parameters:
- EXP_W, 8, exponent width in bits.
- MAN_W, 24, operand mantissa width in bits, hidden bit included.
- TAG_W, 4, width of the sideband transaction tag.
- LAT, 2, pipeline depth in register stages (≥1). Applies uniformly to all operators; sized for the multiplier.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  input transaction present.
- in_ready  out  1  stage can accept this cycle.
- in_sign_1  in  1  sign of operand 1.
- in_sign_2  in  1  sign of operand 2.
- in_exponent  in  EXP_W  shared, pre-aligned exponent; passed through unchanged.
- in_mantissa_1  in  MAN_W  operand 1 magnitude.
- in_mantissa_2  in  MAN_W  operand 2 magnitude.
- in_operator  in  2  00 add, 01 subtract, 10 multiply, 11 reserved.
- in_tag  in  TAG_W  sideband tag; passed through unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts.
- sign  out  1  result sign.
- exponent  out  EXP_W  passed-through exponent.
- mantissa  out  2*MAN_W  unnormalised result magnitude.
- operator  out  2  passed-through operator.
- tag  out  TAG_W  passed-through tag.
- zero  out  1  result mantissa is zero.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - rst=1 clears all stage valid bits and all data registers asynchronously.
  - Output reset values: out_valid=0, sign=0, exponent=0, mantissa=0, operator=0, tag=0, zero=0.
  - in_ready=1 after reset, since the pipeline is empty.
- Advance enable: adv = !out_valid | out_ready. in_ready = adv, which is combinational.
  - When adv=1, all stages shift one place.
  - When adv=0, every stage holds, including outputs. There is no bubble collapsing.
- Accept: a transaction is accepted when in_valid & in_ready. Stage-1 valid loads in_valid & adv.
- Latency: result appears on outputs exactly LAT accepted-advance cycles after acceptance.
  - With out_ready held high, one result per cycle.
  - Results stay in order across all operators.
- Add/subtract datapath (stage 1, combinational into the stage-1 register):
  - Effective sign s2e = in_sign_2 ^ (operator==01).
  - If in_sign_1 == s2e: mantissa = m1 + m2, zero-extended to 2*MAN_W (carry kept in bit MAN_W); sign = in_sign_1.
  - Else, if m1 ≥ m2: mantissa = m1 - m2, sign = in_sign_1.
  - Else: mantissa = m2 - m1, sign = s2e.
  - Exact cancellation (m1 == m2, opposite effective signs): mantissa = 0, sign = 0 (+0).
- Multiply: mantissa = m1 * m2 as a full 2*MAN_W product; sign = in_sign_1 ^ in_sign_2.
  - The product may be computed in stage 1 and carried through, or split across stages, provided total latency equals LAT.
- Reserved operator 11: mantissa = 0, sign = 0, zero = 1; transaction still flows with valid.
- zero is registered with the result: (mantissa == 0).
- exponent, operator and tag are carried unchanged alongside the result.
- Boundaries:
  - Max add: (2^MAN_W - 1) * 2 fits without overflow.
  - Max multiply: (2^MAN_W - 1)^2 fits in 2*MAN_W bits.
  - Zero operands are legal.
  - Stall with in_valid=1: input is not taken; upstream must hold it.
  - Reset asserted mid-pipeline: all in-flight transactions are discarded and nothing appears after rst deasserts.
- Data registers may update on non-valid stages, but out_valid gates their meaning. Verification checks outputs only when out_valid=1, except for the reset values.

Test Plan:
- Add, op 00, signs 0/0, m1=m2=0x800000, exp=0x7F, tag=3 → after LAT cycles: out_valid=1, mantissa=0x000001000000, sign=0, exponent=0x7F, tag=3, zero=0.
- Sub with swap, op 01, signs 0/0, m1=0x400000, m2=0x800000 → mantissa=0x000000400000, sign=1. Also op 00 with signs 1/0 and the same mantissas → mantissa=0x400000, sign=0.
- Multiply, op 10, signs 1/0, m1=m2=0x800000 → mantissa=0x400000000000, sign=1. Also m1=m2=0xFFFFFF → mantissa=0xFFFFFE000001.
- Cancellation and reserved: op 01, signs 1/1, m1=m2=0x123456 → mantissa=0, sign=0, zero=1. Op 11 with any inputs → mantissa=0, zero=1, out_valid=1.
- Back-pressure: stream 5 tagged adds (tags 0..4) with out_ready low for 3 cycles mid-stream →
  - in_ready=0 and outputs stable during the stall;
  - all 5 delivered in tag order, no loss or duplication;
  - throughput 1/cycle once out_ready returns high.
- Reset: assert rst with 2 transactions in flight → out_valid=0 and all outputs 0 immediately, asynchronously; no output after release; in_ready=1.
